seq_mul_arbiter: RTL
====================

// Module: seq_mul_arbiter
// PURPOSE
//   Shares one tt_um_seq_mul sequential multiplier between NREQ requesters.
//   - Picks one pending request by round-robin and latches its operands.
//   - Launches the multiplier with a one-cycle in_valid pulse.
//   - Waits for out_done, or a timeout.
//   - Returns the product to the winning requester.
//   Sits between client blocks and the multiplier; it is the multiplier's only driver.
// PARAMETERS
//   NREQ     4   number of requesters (2..8)
//   W        4   operand width; product is 2*W bits, unsigned
//   TIMEOUT  31  max cycles in WAIT without mul_done before aborting
// PORTS
//   clk           in   1       single clock, rising edge
//   reset         in   1       asynchronous, active-low reset
//   req_valid     in   NREQ    request pending, one bit per requester
//   req_a         in   NREQ*W  operand a; requester i at [i*W +: W]
//   req_b         in   NREQ*W  operand b; same packing as req_a
//   req_ready     out  NREQ    one-hot, one-cycle accept pulse
//   resp_valid    out  NREQ    one-hot, one-cycle response pulse
//   resp_data     out  2*W     product; valid while resp_valid != 0
//   resp_err      out  1       1 = timed out, product invalid
//   busy          out  1       state != IDLE
//   mul_a         out  W       multiplier operand a
//   mul_b         out  W       multiplier operand b
//   mul_in_valid  out  1       multiplier start pulse
//   mul_result    in   2*W     multiplier product
//   mul_done      in   1       multiplier completion pulse
// BEHAVIOUR
//   - All outputs are registered.
//   - Reset (reset=0): state=IDLE, ptr=0, timer=0, every output 0. Reset
//     mid-operation aborts with no response. The multiplier shares this reset.
//   - FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   - IDLE: if req_valid != 0, grant the first set bit searching ptr, ptr+1,
//     ... (mod NREQ). On that edge: latch id, a, b; go to ISSUE.
//   - ISSUE (1 cycle): req_ready[id]=1 and mul_in_valid=1. Then go to WAIT.
//   - Requester rule: hold req_valid and operands until it sees req_ready,
//     then drop req_valid the next cycle. Operands are already latched.
//   - mul_a/mul_b hold the latched operands through ISSUE and WAIT.
//   - WAIT:
//     - timer counts up from 0, one step per WAIT cycle.
//     - mul_done=1: resp_data<=mul_result, resp_err<=0, go to RESP.
//     - Else if timer==TIMEOUT-1: resp_data<=0, resp_err<=1, go to RESP.
//     - mul_done in the same cycle as the timeout: done wins, no error.
//   - RESP (1 cycle): resp_valid[id]=1; ptr<=(id+1) mod NREQ; go to IDLE.
//     resp_data/resp_err hold until the next RESP.
//   - mul_done outside WAIT is stale and ignored.
//   - req_valid changes outside IDLE are ignored.
//   - Latency: selection edge to resp_valid = 2 + (WAIT cycles). Back-to-back
//     grants are possible: RESP goes to IDLE, and IDLE grants the same cycle
//     it sees a request.
//   - Fairness: a continuously asserted requester is served within NREQ grants.
//   - Product is unsigned, 2*W bits, passed through unmodified.
//   - Timer width: $clog2(TIMEOUT+1).
// STRUCTURE
//   - seq_mul_pkg: state encoding localparams (IDLE/ISSUE/WAIT/RESP),
//     default W, and product width 2*W. Shared with the multiplier and benches.
//   - Sub-module rr_arbiter #(NREQ): purely combinational.
//     In: req vector, ptr. Out: one-hot grant, encoded grant id.
//   - Top level holds the FSM, operand/id latches, timer and output registers.
// TESTING
//   - Single request: req_valid=0001, a=3, b=5; model done 4 cycles after
//     start, result 15 -> req_ready=0001 (1 cycle), mul_in_valid single pulse
//     with mul_a=3/mul_b=5, then resp_valid=0001, resp_data=15, resp_err=0.
//   - All four valid after reset, operands (i+1, i+2) -> service order
//     0,1,2,3; resp_data 2, 6, 12, 20.
//   - req0 and req2 held continuously -> grants alternate 0,2,0,2,...;
//     req1/req3 never granted.
//   - Model never asserts done -> exactly TIMEOUT WAIT cycles, then
//     resp_valid[id]=1, resp_err=1, resp_data=0. Next request (a=2, b=7)
//     returns 14 with no error.
//   - reset=0 during WAIT -> all outputs 0 immediately, no resp_valid ever.
//     After release, all requests valid -> requester 0 granted first.
//   - a=15, b=15 -> 225. A mul_done pulse injected in IDLE -> no response,
//     state unchanged.

Source files
------------

// File: rtl/seq_mul_pkg.sv
// Definitions shared by the sequential multiplier, its arbiter and the benches:
// controller state encoding, default operand width and product width.
package seq_mul_pkg;

  localparam int DEFAULT_W = 4;
  localparam int PROD_W    = 2 * DEFAULT_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/seq_mul_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first set request at or after ptr_i,
// wrapping modulo NREQ, returned both one-hot and as an encoded index.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_id_o,
  output logic            any_o
);

  logic [IDW:0] slot;
  logic         found;

  // slot is ptr+k folded back into 0..NREQ-1, so NREQ need not be a power of two
  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    found    = 1'b0;
    slot     = '0;
    for (int k = 0; k < NREQ; k++) begin
      slot = {1'b0, ptr_i} + (IDW+1)'(k);
      if (slot >= (IDW+1)'(NREQ)) begin
        slot = slot - (IDW+1)'(NREQ);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!found && (slot == (IDW+1)'(i)) && req_i[i]) begin
          found    = 1'b1;
          gnt_o[i] = 1'b1;
          gnt_id_o = IDW'(i);
        end
      end
    end
  end

  assign any_o = found;

endmodule

// File: rtl/seq_mul_arbiter.sv
// Shares one sequential multiplier between NREQ requesters: round-robin
// grant, one-cycle launch, wait for done or timeout, one-cycle response.
module seq_mul_arbiter
  import seq_mul_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int W       = DEFAULT_W,
  parameter int TIMEOUT = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   resp_valid,
  output logic [2*W-1:0]    resp_data,
  output logic              resp_err,
  output logic              busy,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  output logic              mul_in_valid,
  input  logic [2*W-1:0]    mul_result,
  input  logic              mul_done
);

  localparam int IDW = $clog2(NREQ);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [IDW-1:0]      id_q, id_d;
  logic [W-1:0]        a_q, a_d;
  logic [W-1:0]        b_q, b_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [NREQ-1:0]     req_ready_q, req_ready_d;
  logic [NREQ-1:0]     resp_valid_q, resp_valid_d;
  logic [2*W-1:0]      resp_data_q, resp_data_d;
  logic                resp_err_q, resp_err_d;
  logic                busy_q, busy_d;
  logic                mul_in_valid_q, mul_in_valid_d;

  logic [NREQ-1:0]     gnt_oh;
  logic [IDW-1:0]      gnt_id;
  logic                gnt_any;
  logic [W-1:0]        a_sel, b_sel;
  logic [NREQ-1:0]     id_oh;
  logic [IDW-1:0]      ptr_next;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req_i    (req_valid),
    .ptr_i    (ptr_q),
    .gnt_o    (gnt_oh),
    .gnt_id_o (gnt_id),
    .any_o    (gnt_any)
  );

  // Operand mux for the winner and one-hot decode of the latched id
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    id_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == IDW'(i)) begin
        a_sel = req_a[i*W +: W];
        b_sel = req_b[i*W +: W];
      end
      id_oh[i] = (id_q == IDW'(i));
    end
  end

  assign ptr_next = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);

  // Next-state logic; every output is computed one cycle ahead so it is registered
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    id_d           = id_q;
    a_d            = a_q;
    b_d            = b_q;
    timer_d        = timer_q;
    req_ready_d    = '0;
    resp_valid_d   = '0;
    resp_data_d    = resp_data_q;
    resp_err_d     = resp_err_q;
    mul_in_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          id_d           = gnt_id;
          a_d            = a_sel;
          b_d            = b_sel;
          req_ready_d    = gnt_oh;
          mul_in_valid_d = 1'b1;
          timer_d        = '0;
          state_d        = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving on the last allowed cycle still counts as success
        if (mul_done) begin
          resp_data_d  = mul_result;
          resp_err_d   = 1'b0;
          resp_valid_d = id_oh;
          timer_d      = '0;
          state_d      = S_RESP;
        end else if (timer_q == TLAST) begin
          resp_data_d  = '0;
          resp_err_d   = 1'b1;
          resp_valid_d = id_oh;
          timer_d      = '0;
          state_d      = S_RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RESP: begin
        ptr_d   = ptr_next;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      ptr_q          <= '0;
      id_q           <= '0;
      a_q            <= '0;
      b_q            <= '0;
      timer_q        <= '0;
      req_ready_q    <= '0;
      resp_valid_q   <= '0;
      resp_data_q    <= '0;
      resp_err_q     <= 1'b0;
      busy_q         <= 1'b0;
      mul_in_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      id_q           <= id_d;
      a_q            <= a_d;
      b_q            <= b_d;
      timer_q        <= timer_d;
      req_ready_q    <= req_ready_d;
      resp_valid_q   <= resp_valid_d;
      resp_data_q    <= resp_data_d;
      resp_err_q     <= resp_err_d;
      busy_q         <= busy_d;
      mul_in_valid_q <= mul_in_valid_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;
  assign resp_err     = resp_err_q;
  assign busy         = busy_q;
  assign mul_a        = a_q;
  assign mul_b        = b_q;
  assign mul_in_valid = mul_in_valid_q;

endmodule
